// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types and constants for the committed-store buffer.
package store_buffer_pkg;

    typedef logic bool;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } ldst_mode_t;

    typedef struct packed {
        ldst_mode_t  mode;
        logic [31:2] waddr;
        logic [1:0]  boff;
        logic [31:0] data;
    } sb_entry_t;

    localparam int SB_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: commit push, memory drain and load lookup signals of the store buffer.
interface store_buffer_if;
    import store_buffer_pkg::*;

    bool         store_enable;
    ldst_mode_t  store_mode;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    bool         full;
    bool         empty;
    bool         overflow;
    bool         mem_req;
    ldst_mode_t  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    bool         mem_ack;
    logic [31:0] load_addr;
    ldst_mode_t  load_mode;
    bool         fwd_hit;
    logic [31:0] fwd_data;
    bool         fwd_conflict;

    modport master (
        output store_enable, store_mode, store_addr, store_data, mem_ack, load_addr, load_mode,
        input  full, empty, overflow, mem_req, mem_mode, mem_addr, mem_data,
               fwd_hit, fwd_data, fwd_conflict
    );

    modport slave (
        input  store_enable, store_mode, store_addr, store_data, mem_ack, load_addr, load_mode,
        output full, empty, overflow, mem_req, mem_mode, mem_addr, mem_data,
               fwd_hit, fwd_data, fwd_conflict
    );

endinterface

// File: rtl/store_buffer_fwd.sv
// store_forward_unit: youngest-first word-address search over buffered stores for load lookups.
// STORE_FORWARD_EN enables data forwarding; without it every match is reported as a conflict.
module store_forward_unit
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  sb_entry_t                 ent_i [DEPTH],
    input  logic [DEPTH-1:0]          valid_i,
    input  logic [$clog2(DEPTH)-1:0]  head_i,
    input  logic [31:0]               load_addr_i,
    input  ldst_mode_t                load_mode_i,
    output bool                       hit_o,
    output logic [31:0]               data_o,
    output bool                       conflict_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;
    bool           match;
    sb_entry_t     youngest;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        match    = 1'b0;
        youngest = '0;
        idx      = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PW'(k);
            if (valid_i[idx] && ent_i[idx].waddr == load_addr_i[31:2]) begin
                match    = 1'b1;
                youngest = ent_i[idx];
            end
        end
    end

`ifdef STORE_FORWARD_EN
    assign hit_o      = match && youngest.mode == WORD && load_mode_i == WORD;
    assign data_o     = hit_o ? youngest.data : '0;
    assign conflict_o = match && !hit_o;
    logic unused_fwd;
    assign unused_fwd = ^{youngest.boff, load_addr_i[1:0]};
`else
    assign hit_o      = 1'b0;
    assign data_o     = '0;
    assign conflict_o = match;
    logic unused_fwd;
    assign unused_fwd = ^{youngest.boff, youngest.mode, youngest.data, load_addr_i[1:0], load_mode_i};
`endif

endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of committed stores drained oldest-first over mem_req/mem_ack.
// Load lookups go through store_forward_unit; STORE_FORWARD_EN selects forwarding vs conflict-only.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        ent_q [DEPTH];
    sb_entry_t        head_e;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    bool              ovf_q, ovf_d;
    logic [DEPTH-1:0] valid;
    bool              full, empty, push, pop;

    assign full   = count_q == CW'(DEPTH);
    assign empty  = count_q == '0;
    assign push   = bus.store_enable && !full;
    assign pop    = !empty && bus.mem_ack;
    assign head_e = ent_q[head_q];

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
        ovf_d   = ovf_q || (bus.store_enable && full);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push)
            ent_q[tail_q] <= '{mode: bus.store_mode, waddr: bus.store_addr[31:2],
                               boff: bus.store_addr[1:0], data: bus.store_data};
    end

    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++)
            valid[i] = {1'b0, PW'(i) - head_q} < count_q;
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.overflow = ovf_q;
    assign bus.mem_req  = !empty;
    assign bus.mem_mode = empty ? WORD : head_e.mode;
    assign bus.mem_addr = empty ? '0 : {head_e.waddr, head_e.boff};
    assign bus.mem_data = empty ? '0 : head_e.data;

    store_forward_unit #(.DEPTH(DEPTH)) u_fwd (
        .ent_i       (ent_q),
        .valid_i     (valid),
        .head_i      (head_q),
        .load_addr_i (bus.load_addr),
        .load_mode_i (bus.load_mode),
        .hit_o       (bus.fwd_hit),
        .data_o      (bus.fwd_data),
        .conflict_o  (bus.fwd_conflict)
    );

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vector table, hand-written corner sequences and a queue-based random model.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;
`ifdef STORE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_buffer_if bus();
    store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct { ldst_mode_t m; logic [31:0] a; logic [31:0] d; } ent_t;
    typedef struct {
        bit en; ldst_mode_t m; logic [31:0] a; logic [31:0] d; bit ack; logic [31:0] la; ldst_mode_t lm;
        bit req; bit full; bit ovf; ldst_mode_t mm; logic [31:0] ma; logic [31:0] md;
        bit hit; logic [31:0] fd; bit conf;
    } vec_t;

    vec_t tbl[$];
    ent_t q[$];

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drv(bit en, ldst_mode_t m, logic [31:0] a, logic [31:0] d, bit ack,
                       logic [31:0] la, ldst_mode_t lm);
        bus.store_enable = en;
        bus.store_mode   = m;
        bus.store_addr   = a;
        bus.store_data   = d;
        bus.mem_ack      = ack;
        bus.load_addr    = la;
        bus.load_mode    = lm;
    endtask

    task automatic outs(string t, bit req, bit full, bit ovf, ldst_mode_t mm, logic [31:0] ma,
                        logic [31:0] md, bit hit, logic [31:0] fd, bit conf);
        chk({t, " mem_req"},      32'(bus.mem_req),      32'(req));
        chk({t, " empty"},        32'(bus.empty),        32'(!req));
        chk({t, " full"},         32'(bus.full),         32'(full));
        chk({t, " overflow"},     32'(bus.overflow),     32'(ovf));
        chk({t, " mem_mode"},     32'(bus.mem_mode),     32'(mm));
        chk({t, " mem_addr"},     bus.mem_addr,          ma);
        chk({t, " mem_data"},     bus.mem_data,          md);
        chk({t, " fwd_hit"},      32'(bus.fwd_hit),      32'(hit));
        chk({t, " fwd_data"},     bus.fwd_data,          fd);
        chk({t, " fwd_conflict"}, 32'(bus.fwd_conflict), 32'(conf));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit en, ack, e_req, e_full, e_hit, e_conf, found, ovf;
        ldst_mode_t m, lm, e_mm, fm;
        logic [31:0] a, d, la, e_ma, e_md, e_fd, fdv;

        // en m a d ack la lm | req full ovf mm ma md hit fd conf
        tbl.push_back('{0, WORD, 32'h0,   32'h0,        0, 32'h0,   WORD, 0, 0, 0, WORD, 32'h0,   32'h0,        0,   32'h0,                         0});
        tbl.push_back('{1, WORD, 32'h100, 32'hDEADBEEF, 1, 32'h0,   WORD, 0, 0, 0, WORD, 32'h0,   32'h0,        0,   32'h0,                         0});
        tbl.push_back('{0, WORD, 32'h0,   32'h0,        1, 32'h100, WORD, 1, 0, 0, WORD, 32'h100, 32'hDEADBEEF, FWD, FWD ? 32'hDEADBEEF : 32'h0, !FWD});
        tbl.push_back('{0, WORD, 32'h0,   32'h0,        1, 32'h100, WORD, 0, 0, 0, WORD, 32'h0,   32'h0,        0,   32'h0,                         0});
        tbl.push_back('{1, WORD, 32'h200, 32'h11,       0, 32'h200, WORD, 0, 0, 0, WORD, 32'h0,   32'h0,        0,   32'h0,                         0});
        tbl.push_back('{1, WORD, 32'h200, 32'h22,       0, 32'h200, WORD, 1, 0, 0, WORD, 32'h200, 32'h11,       FWD, FWD ? 32'h11 : 32'h0,       !FWD});
        tbl.push_back('{1, BYTE, 32'h201, 32'hAA,       0, 32'h200, WORD, 1, 0, 0, WORD, 32'h200, 32'h11,       FWD, FWD ? 32'h22 : 32'h0,       !FWD});
        tbl.push_back('{0, WORD, 32'h0,   32'h0,        0, 32'h200, WORD, 1, 0, 0, WORD, 32'h200, 32'h11,       0,   32'h0,                         1});
        tbl.push_back('{0, WORD, 32'h0,   32'h0,        0, 32'h204, WORD, 1, 0, 0, WORD, 32'h200, 32'h11,       0,   32'h0,                         0});
        tbl.push_back('{1, WORD, 32'h300, 32'h33,       0, 32'h202, HALF, 1, 0, 0, WORD, 32'h200, 32'h11,       0,   32'h0,                         1});
        tbl.push_back('{1, WORD, 32'h400, 32'h44,       0, 32'h300, WORD, 1, 1, 0, WORD, 32'h200, 32'h11,       FWD, FWD ? 32'h33 : 32'h0,       !FWD});
        tbl.push_back('{0, WORD, 32'h0,   32'h0,        1, 32'h400, WORD, 1, 1, 1, WORD, 32'h200, 32'h11,       0,   32'h0,                         0});
        tbl.push_back('{0, WORD, 32'h0,   32'h0,        1, 32'h400, WORD, 1, 0, 1, WORD, 32'h200, 32'h22,       0,   32'h0,                         0});
        tbl.push_back('{0, WORD, 32'h0,   32'h0,        1, 32'h400, WORD, 1, 0, 1, BYTE, 32'h201, 32'hAA,       0,   32'h0,                         0});
        tbl.push_back('{0, WORD, 32'h0,   32'h0,        1, 32'h400, WORD, 1, 0, 1, WORD, 32'h300, 32'h33,       0,   32'h0,                         0});
        tbl.push_back('{0, WORD, 32'h0,   32'h0,        0, 32'h400, WORD, 0, 0, 1, WORD, 32'h0,   32'h0,        0,   32'h0,                         0});

        reset = 1'b1;
        drv(0, WORD, 0, 0, 0, 0, WORD);
        repeat (2) @(posedge clk);
        #1;
        outs("reset", 0, 0, 0, WORD, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();

        foreach (tbl[i]) begin
            drv(tbl[i].en, tbl[i].m, tbl[i].a, tbl[i].d, tbl[i].ack, tbl[i].la, tbl[i].lm);
            #1;
            outs($sformatf("row%0d", i), tbl[i].req, tbl[i].full, tbl[i].ovf, tbl[i].mm,
                 tbl[i].ma, tbl[i].md, tbl[i].hit, tbl[i].fd, tbl[i].conf);
            tick();
        end

        // One entry held under a stalled memory for five cycles, then a single ack.
        drv(1, WORD, 32'h500, 32'h55, 0, 32'h504, WORD);
        #1;
        outs("stall0", 0, 0, 1, WORD, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drv(0, WORD, 0, 0, 0, 32'h504, WORD);
            #1;
            outs($sformatf("stall%0d", i + 1), 1, 0, 1, WORD, 32'h500, 32'h55, 0, 0, 0);
            tick();
        end
        drv(0, WORD, 0, 0, 1, 32'h504, WORD);
        #1;
        outs("stall_ack", 1, 0, 1, WORD, 32'h500, 32'h55, 0, 0, 0);
        tick();
        drv(0, WORD, 0, 0, 0, 32'h504, WORD);
        #1;
        outs("stall_done", 0, 0, 1, WORD, 0, 0, 0, 0, 0);
        tick();

        // Fill, then push and pop together while full: the push must be dropped.
        for (int i = 0; i < 4; i++) begin
            drv(1, WORD, 32'hA00 + 32'(4 * i), 32'(i + 1), 0, 32'hB00, WORD);
            tick();
        end
        drv(1, WORD, 32'hB00, 32'hBB, 1, 32'hB00, WORD);
        #1;
        outs("full_pushpop", 1, 1, 1, WORD, 32'hA00, 32'h1, 0, 0, 0);
        tick();
        drv(0, WORD, 0, 0, 0, 32'hB00, WORD);
        #1;
        outs("after_pushpop", 1, 0, 1, WORD, 32'hA04, 32'h2, 0, 0, 0);
        #1;
        reset = 1'b1;
        #1;
        outs("async_reset", 0, 0, 0, WORD, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(0, WORD, 0, 0, 1, 32'hA04, WORD);
            #1;
            outs($sformatf("post_reset%0d", i), 0, 0, 0, WORD, 0, 0, 0, 0, 0);
            tick();
        end

        ovf = 1'b0;
        for (int c = 0; c < 400; c++) begin
            en  = 1'($urandom_range(0, 1));
            m   = ldst_mode_t'($urandom_range(0, 2));
            a   = 32'h200 + 32'($urandom_range(0, 15));
            d   = $urandom;
            ack = 1'($urandom_range(0, 1));
            la  = 32'h200 + 32'($urandom_range(0, 19));
            lm  = ldst_mode_t'($urandom_range(0, 2));
            drv(en, m, a, d, ack, la, lm);
            #1;
            e_req  = q.size() != 0;
            e_full = q.size() == DEPTH;
            e_mm   = WORD;
            e_ma   = 32'h0;
            e_md   = 32'h0;
            if (e_req) begin
                e_mm = q[0].m;
                e_ma = q[0].a;
                e_md = q[0].d;
            end
            found = 1'b0;
            fm    = WORD;
            fdv   = 32'h0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!found && q[i].a[31:2] == la[31:2]) begin
                    found = 1'b1;
                    fm    = q[i].m;
                    fdv   = q[i].d;
                end
            end
            e_hit  = found && FWD && fm == WORD && lm == WORD;
            e_fd   = e_hit ? fdv : 32'h0;
            e_conf = found && !e_hit;
            outs("rnd", e_req, e_full, ovf, e_mm, e_ma, e_md, e_hit, e_fd, e_conf);
            @(posedge clk);
            if (en && e_full) ovf = 1'b1;
            if (e_req && ack) void'(q.pop_front());
            if (en && !e_full) q.push_back('{m, a, d});
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Committed-store buffer that receives the single store per cycle emitted by the commit stage and drains those stores, oldest first, to the data-memory write port over a req/ack handshake. It sits between commit and data memory. It decouples in-order retirement from memory write latency. It answers load-address lookups so loads issued after a committed store observe that store's data or wait for it.

## Interface

Parameters:
- `DEPTH`, default 4: number of entries; power of two, ≥2.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `store_enable`: input, bool. Commit presents a store this cycle.
- `store_mode`: input, `ldst_mode_t`. Store width: BYTE, HALF or WORD.
- `store_addr`: input, 32 bits. Byte address.
- `store_data`: input, 32 bits. Data, right-aligned.
- `full`: output, bool. `count == DEPTH`. Commit must not retire a store while this is high.
- `empty`: output, bool. `count == 0`. Used for fences and halt.
- `overflow`: output, bool. Sticky. Set when a push arrives while `full`.
- `mem_req`: output, bool. Head entry is valid.
- `mem_mode`: output, `ldst_mode_t`. Head entry's mode.
- `mem_addr`: output, 32 bits. Head entry's address.
- `mem_data`: output, 32 bits. Head entry's data.
- `mem_ack`: input, bool. Memory accepted the head entry this cycle.
- `load_addr`: input, 32 bits. Address being looked up by the load unit.
- `load_mode`: input, `ldst_mode_t`. Width of the load being looked up.
- `fwd_hit`: output, bool. `fwd_data` is valid for this load.
- `fwd_data`: output, 32 bits. Forwarded word.
- `fwd_conflict`: output, bool. The load must stall and retry.

## Operation

- Circular FIFO of `DEPTH` entries `{mode, addr, data}` with head pointer, tail pointer and count. Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. Count is `$clog2(DEPTH)+1` bits wide.
- Push: `store_enable && !full` writes the tail entry, increments tail, and increments count.
- Push while `full`: the store is dropped and `overflow` is set. `overflow` stays set until reset.
- `full` is the pre-edge state. A push and a pop in the same cycle while full still drops the push.
- Pop: `mem_req && mem_ack` increments head and decrements count. `mem_ack` while `!mem_req` is ignored.
- Push and pop in the same cycle, not full: count is unchanged and both pointers advance.
- Memory outputs are driven from the head entry. `mem_req = !empty`. `mem_addr`, `mem_data` and `mem_mode` stay stable while `mem_req` is high and `mem_ack` is low.
- When `mem_req` is low, `mem_mode` is WORD and `mem_addr` and `mem_data` are 0.
- Forwarding is combinational. Valid entries are compared on `addr[31:2]` against `load_addr[31:2]`. The youngest matching entry wins.
  - If the youngest match is WORD mode and `load_mode` is WORD: `fwd_hit=1`, `fwd_data` is that entry's data, `fwd_conflict=0`.
  - If there is any other match: `fwd_hit=0`, `fwd_conflict=1`.
  - If there is no match: both outputs are 0, and `fwd_data` is 0.
- The lookup sees only pre-edge entries. A store pushed this cycle is not visible until the next cycle.

## Timing

- Reset values: head=0, tail=0, count=0, `overflow=0`, `empty=1`, `full=0`, `mem_req=0`, `mem_mode=WORD`, `mem_addr=0`, `mem_data=0`, `fwd_*=0`.
- Reset asserted mid-drain discards all entries immediately. Committed stores are lost by design, because reset aborts the core.
- Push to `mem_req` latency is 1 cycle, so a store pushed at edge N is presented after edge N.
- Back-to-back drain: when ack arrives at edge N, the next entry is on the `mem_*` outputs after edge N. Sustained throughput is 1 store per cycle.
- Forwarding outputs depend combinationally on `load_*` and registered state only. There is no path from `store_*`.

## Configuration

- Macro `STORE_FORWARD_EN`.
- Defined: forwarding behaves as described in Operation.
- Undefined:
  - `fwd_hit=0` and `fwd_data=0` always.
  - `fwd_conflict=1` whenever any valid entry matches on `addr[31:2]`.
  - The data-compare mux is removed.
- The conflict comparators remain in both builds.

## Structure

- Shared package contents:
  - `bool` and `ldst_mode_t`, which are existing types.
  - New `sb_entry_t` struct `{ldst_mode_t mode; logic [31:2] waddr; logic [1:0] boff; logic [31:0] data;}`.
  - Constant `SB_DEPTH_DEFAULT = 4`.
- One sub-module: `store_forward_unit`. It is combinational. Inputs are the entry array, a valid mask, head and the load request. Outputs are hit, data and conflict. It performs the youngest-first priority search.
- The FIFO and handshake logic stay in `store_buffer`.

## Test plan

- Reset, then push WORD 0x100 / 0xDEADBEEF, with `mem_ack` tied high: `mem_req` rises 1 cycle later with addr 0x100 and data 0xDEADBEEF. `empty=1` the cycle after.
- Push 4 stores with `mem_ack=0`, then a 5th: `full=1` after the 4th. The 5th is dropped and `overflow=1`. Release ack: exactly 4 stores drain, in order, on consecutive cycles.
- Hold `mem_ack=0` for 5 cycles with one entry: `mem_*` stay constant and `mem_req` stays 1. Ack once: `mem_req=0` the next cycle.
- Push WORD 0x200/0x11 then WORD 0x200/0x22, then load WORD 0x200: `fwd_hit=1`, `fwd_data=0x22`.
- Push BYTE 0x201/0xAA, then load WORD 0x200: `fwd_conflict=1` and `fwd_hit=0`. Load 0x204: all fwd outputs are 0. With `STORE_FORWARD_EN` undefined, the WORD case also yields conflict.
- Assert `reset` with 3 entries pending and `mem_req` high: `mem_req=0` and `empty=1` immediately, asynchronously. No further `mem_req` after reset is released.
